// File: rtl/neuron_ctrl_pkg.sv
// rtl/neuron_ctrl_pkg.sv - shared state encoding and defaults for the neuron sequencer
package neuron_ctrl_pkg;

    localparam int DEPTH_DEF     = 64;
    localparam int OUT_DELAY_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_THR = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_COMPUTE  = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_DONE     = 3'd6
    } nseq_state_t;

endpackage

// File: rtl/neuron_ptr_cnt.sv
// rtl/neuron_ptr_cnt.sv - pointer counter with clear, enable and limit compare
module neuron_ptr_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         at_limit
);

    // Clear wins over enable; the caller never enables at the limit, so no wrap occurs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == limit);

endmodule

// File: rtl/neuron_seq_ctrl.sv
// rtl/neuron_seq_ctrl.sv - load/threshold/clear/compute/drain sequencer for one neuron datapath
module neuron_seq_ctrl
    import neuron_ctrl_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PTR_W     = $clog2(DEPTH),
    parameter int OUT_DELAY = OUT_DELAY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chip_sel,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] last_idx,
    input  logic             threshold_ready,
    output logic             rst_mem,
    output logic             mul_mem_en,
    output logic             ac_mem_en,
    output logic [PTR_W-1:0] wr_data_ptr,
    output logic [PTR_W-1:0] rd_data_ptr,
    output logic             output_ready,
    output logic             busy,
    output logic             abort
);

    localparam int              DLY_W    = (OUT_DELAY > 1) ? $clog2(OUT_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(OUT_DELAY - 1);
    localparam logic [PTR_W-1:0] LEN_RST  = PTR_W'(DEPTH - 1);

    nseq_state_t      state_q, state_d;
    logic [PTR_W-1:0] len_q;
    logic [DLY_W-1:0] dly_q;
    logic             abort_q;

    logic             len_ld;
    logic             wr_inc, rd_inc, rd_clr, ptr_clr;
    logic             dly_clr, dly_inc;
    logic             abort_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             wr_at_lim, rd_at_lim;

    neuron_ptr_cnt #(.W(PTR_W)) u_wr_ptr (
        .clk      (clk),
        .rst      (rst),
        .clr      (ptr_clr),
        .en       (wr_inc),
        .limit    (len_q),
        .cnt      (wr_ptr),
        .at_limit (wr_at_lim)
    );

    neuron_ptr_cnt #(.W(PTR_W)) u_rd_ptr (
        .clk      (clk),
        .rst      (rst),
        .clr      (ptr_clr | rd_clr),
        .en       (rd_inc),
        .limit    (len_q),
        .cnt      (rd_ptr),
        .at_limit (rd_at_lim)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Vector length, drain counter and the registered abort pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q   <= LEN_RST;
            dly_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= abort_d;
            if (len_ld) begin
                len_q <= last_idx;
            end
            if (dly_clr) begin
                dly_q <= '0;
            end else if (dly_inc) begin
                dly_q <= dly_q + 1'b1;
            end
        end
    end

    // Next-state, counter strobes, and outputs decoded from registered state only.
    always_comb begin
        state_d      = state_q;
        len_ld       = 1'b0;
        wr_inc       = 1'b0;
        rd_inc       = 1'b0;
        rd_clr       = 1'b0;
        ptr_clr      = 1'b0;
        dly_clr      = 1'b0;
        dly_inc      = 1'b0;
        abort_d      = 1'b0;

        rst_mem      = (state_q == ST_CLEAR);
        mul_mem_en   = (state_q == ST_COMPUTE);
        ac_mem_en    = (state_q == ST_COMPUTE);
        output_ready = (state_q == ST_DONE);
        busy         = (state_q != ST_IDLE);
        abort        = abort_q;
        wr_data_ptr  = (state_q == ST_IDLE) ? '0 : wr_ptr;
        rd_data_ptr  = (state_q == ST_COMPUTE) ? rd_ptr : '0;

        case (state_q)
            ST_IDLE: begin
                if (chip_sel && wr_en) begin
                    len_ld = 1'b1;
                    if (last_idx == '0) begin
                        state_d = ST_WAIT_THR;
                    end else begin
                        state_d = ST_LOAD;
                        wr_inc  = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (wr_en) begin
                    if (wr_at_lim) begin
                        state_d = ST_WAIT_THR;
                    end else begin
                        wr_inc = 1'b1;
                    end
                end
            end
            ST_WAIT_THR: begin
                if (threshold_ready) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                rd_clr  = 1'b1;
                state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (rd_at_lim) begin
                    state_d = ST_DRAIN;
                    dly_clr = 1'b1;
                end else begin
                    rd_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                dly_inc = 1'b1;
                if (dly_q == DLY_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!chip_sel) begin
                    state_d = ST_IDLE;
                    ptr_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_clr = 1'b1;
            end
        endcase

        // Losing chip_sel mid-transaction cancels everything else this cycle.
        if (!chip_sel && (state_q inside {ST_LOAD, ST_WAIT_THR, ST_CLEAR, ST_COMPUTE, ST_DRAIN})) begin
            state_d = ST_IDLE;
            abort_d = 1'b1;
            ptr_clr = 1'b1;
            wr_inc  = 1'b0;
            rd_inc  = 1'b0;
            rd_clr  = 1'b0;
            dly_clr = 1'b0;
            dly_inc = 1'b0;
        end
    end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// tb/tb_neuron_seq_ctrl.sv - directed and randomized transactions against a timing model
module tb_neuron_seq_ctrl;

    localparam int DEPTH     = 64;
    localparam int PTR_W     = 6;
    localparam int OUT_DELAY = 2;

    logic             clk;
    logic             rst;
    logic             chip_sel;
    logic             wr_en;
    logic [PTR_W-1:0] last_idx;
    logic             threshold_ready;
    logic             rst_mem;
    logic             mul_mem_en;
    logic             ac_mem_en;
    logic [PTR_W-1:0] wr_data_ptr;
    logic [PTR_W-1:0] rd_data_ptr;
    logic             output_ready;
    logic             busy;
    logic             abort;

    int n_vec = 0;
    int n_err = 0;

    neuron_seq_ctrl #(
        .DEPTH     (DEPTH),
        .OUT_DELAY (OUT_DELAY)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .chip_sel        (chip_sel),
        .wr_en           (wr_en),
        .last_idx        (last_idx),
        .threshold_ready (threshold_ready),
        .rst_mem         (rst_mem),
        .mul_mem_en      (mul_mem_en),
        .ac_mem_en       (ac_mem_en),
        .wr_data_ptr     (wr_data_ptr),
        .rd_data_ptr     (rd_data_ptr),
        .output_ready    (output_ready),
        .busy            (busy),
        .abort           (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rst_mem"}, rst_mem, 0);
        chk({tag, "_mul"}, mul_mem_en, 0);
        chk({tag, "_ac"}, ac_mem_en, 0);
        chk({tag, "_wptr"}, wr_data_ptr, 0);
        chk({tag, "_rptr"}, rd_data_ptr, 0);
        chk({tag, "_ordy"}, output_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_abort"}, abort, 0);
    endtask

    // One host transaction. The expected trace follows from the protocol rules:
    // len+1 accepted writes, one clear cycle, len+1 compute cycles, OUT_DELAY drain
    // cycles, then output_ready until chip_sel drops.
    // gap_mode: 0 = wr_en always high, 1 = alternate 0/1 after the first write, 2 = random.
    task automatic txn(input int len, input int gap_mode, input int thr_wait, input int hold,
                       input int abort_cc, input bit chg_len, input bit rst_drain);
        int acc;
        int cyc;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_wptr", wr_data_ptr, 0);
        chk("idle_ordy", output_ready, 0);
        chip_sel        = 1'b1;
        wr_en           = 1'b1;
        last_idx        = PTR_W'(len);
        threshold_ready = 1'b0;
        @(negedge clk);
        acc = 1;
        cyc = 0;
        while (acc <= len && cyc < 2000) begin
            chk("load_busy", busy, 1);
            chk("load_wptr", wr_data_ptr, acc);
            chk("load_noen", mul_mem_en, 0);
            case (gap_mode)
                0:       wr_en = 1'b1;
                1:       wr_en = (cyc % 2) == 1;
                default: wr_en = ($urandom_range(0, 3) != 0);
            endcase
            if (chg_len) last_idx = PTR_W'($urandom);
            @(negedge clk);
            if (wr_en) acc++;
            cyc++;
        end
        chk("load_count", acc, len + 1);

        for (int i = 0; i < thr_wait; i++) begin
            chk("wthr_busy", busy, 1);
            chk("wthr_wptr", wr_data_ptr, len);
            chk("wthr_rst_mem", rst_mem, 0);
            chk("wthr_mul", mul_mem_en, 0);
            chk("wthr_ac", ac_mem_en, 0);
            chk("wthr_ordy", output_ready, 0);
            wr_en = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        threshold_ready = 1'b1;
        @(negedge clk);
        threshold_ready = 1'b0;
        wr_en           = 1'($urandom_range(0, 1));
        chk("clear_pulse", rst_mem, 1);
        chk("clear_noen", mul_mem_en, 0);
        chk("clear_busy", busy, 1);
        @(negedge clk);

        for (int i = 0; i <= len; i++) begin
            chk("comp_mul", mul_mem_en, 1);
            chk("comp_ac", ac_mem_en, 1);
            chk("comp_rptr", rd_data_ptr, i);
            chk("comp_rst_mem", rst_mem, 0);
            chk("comp_ordy", output_ready, 0);
            chk("comp_wptr", wr_data_ptr, len);
            if (i == abort_cc) chip_sel = 1'b0;
            @(negedge clk);
            if (i == abort_cc) begin
                chk("abort_pulse", abort, 1);
                chk("abort_busy", busy, 0);
                chk("abort_mul", mul_mem_en, 0);
                chk("abort_ac", ac_mem_en, 0);
                chk("abort_ordy", output_ready, 0);
                wr_en = 1'b0;
                @(negedge clk);
                chk("abort_once", abort, 0);
                for (int k = 0; k < 4; k++) begin
                    chk("abort_no_ordy", output_ready, 0);
                    chk("abort_idle", busy, 0);
                    @(negedge clk);
                end
                return;
            end
        end

        for (int d = 0; d < OUT_DELAY; d++) begin
            if (rst_drain && d == 0) begin
                #2 rst = 1'b1;
                #1 chk_all_zero("rst_drain");
                #1 rst = 1'b0;
                chip_sel = 1'b0;
                wr_en    = 1'b0;
                @(negedge clk);
                chk("post_rst_busy", busy, 0);
                chk("post_rst_ordy", output_ready, 0);
                return;
            end
            chk("drain_busy", busy, 1);
            chk("drain_ordy", output_ready, 0);
            chk("drain_mul", mul_mem_en, 0);
            chk("drain_rst_mem", rst_mem, 0);
            @(negedge clk);
        end

        for (int h = 0; h < hold; h++) begin
            chk("done_ordy", output_ready, 1);
            chk("done_busy", busy, 1);
            chk("done_mul", mul_mem_en, 0);
            chk("done_abort", abort, 0);
            if (h == hold - 1) chip_sel = 1'b0;
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("exit_ordy", output_ready, 0);
        chk("exit_busy", busy, 0);
        chk("exit_abort", abort, 0);
        chk("exit_wptr", wr_data_ptr, 0);
    endtask

    initial begin
        int len;
        int abort_cc;
        rst             = 1'b1;
        chip_sel        = 1'b0;
        wr_en           = 1'b0;
        last_idx        = '0;
        threshold_ready = 1'b0;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("after_reset");

        txn(63, 0, 3,   4, -1, 1'b0, 1'b0);
        txn(2,  1, 5,   2, -1, 1'b1, 1'b0);
        txn(0,  0, 2,   3, -1, 1'b0, 1'b0);
        txn(20, 0, 1,   1,  9, 1'b0, 1'b0);
        txn(10, 2, 2,   1, -1, 1'b0, 1'b1);
        txn(63, 0, 0,   3, -1, 1'b0, 1'b0);
        txn(5,  2, 100, 2, -1, 1'b0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            len      = $urandom_range(0, DEPTH - 1);
            abort_cc = -1;
            if ($urandom_range(0, 3) == 0) abort_cc = $urandom_range(0, len);
            txn(len, 2, $urandom_range(0, 4), $urandom_range(1, 4), abort_cc,
                1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
